dot_product_operand_loader: RTL and testbench

DOT_PRODUCT_OPERAND_LOADER -- requirements
Module: dot_product_operand_loader

---
 rtl/dot_product_operand_loader_pkg.sv | 20 ++
 rtl/dot_product_operand_loader_operand_lane_bank.sv | 52 +++++
 rtl/dot_product_operand_loader.sv | 107 ++++++++++
 tb/tb_dot_product_operand_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_operand_loader_pkg.sv
// Shared sizing constants for the dot-product operand loader.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package dot_product_operand_loader_pkg;

  // Default number of elements per vector.
  localparam int VEC_LEN_DEF = 16;

  // Width of the issued-vector counter; it wraps at 2^VCNT_W.
  localparam int VCNT_W = 16;

  // Index width for an n-element vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index width matching the default vector length.
  localparam int IDX_W_DEF = idx_width(VEC_LEN_DEF);

endpackage

// File: rtl/dot_product_operand_loader_operand_lane_bank.sv
// Staging and output register bank for one operand (serial element -> parallel vector).
// Latency: output register loads on the edge that accepts the last element.
// Backpressure: none; writes are qualified by i_wr_en, which already folds in the clock enable.
module operand_lane_bank
  import dot_product_operand_loader_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int VEC_LEN  = VEC_LEN_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic                         i_copy,
  input  logic [IDX_W-1:0]             i_lane,
  input  logic [IN_WIDTH-1:0]          i_dat,
  output logic [VEC_LEN*IN_WIDTH-1:0]  o_flat
);

  logic [VEC_LEN*IN_WIDTH-1:0] r_stage;
  logic [VEC_LEN*IN_WIDTH-1:0] r_flat;
  logic [VEC_LEN*IN_WIDTH-1:0] w_merged;

  // Staging image with the incoming element already placed in its lane, so the
  // copy captures the last element in the same edge that accepts it.
  always_comb begin
    w_merged = r_stage;
    for (int k = 0; k < VEC_LEN; k++) begin
      if (i_lane == IDX_W'(k)) begin
        w_merged[k*IN_WIDTH +: IN_WIDTH] = i_dat;
      end
    end
  end

  // Staging lanes follow accepted elements; output lanes load only on a copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
      r_flat  <= '0;
    end else begin
      if (i_wr_en) begin
        r_stage <= w_merged;
      end
      if (i_copy) begin
        r_flat <= w_merged;
      end
    end
  end

  assign o_flat = r_flat;

endmodule

// File: rtl/dot_product_operand_loader.sv
// Collects serial A/B element pairs into parallel vectors for a dot-product engine.
// Latency: outReady one cycle after the last element of a vector is accepted.
// Backpressure: none upstream; enable=0 freezes all state, stretching outReady.
module dot_product_operand_loader
  import dot_product_operand_loader_pkg::*;
#(
  parameter int IN_WIDTH = 10,
  parameter int VEC_LEN  = VEC_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         inValid,
  input  logic                         inStart,
  input  logic signed [IN_WIDTH-1:0]   inA,
  input  logic signed [IN_WIDTH-1:0]   inB,
  output logic [VEC_LEN*IN_WIDTH-1:0]  A_flat,
  output logic [VEC_LEN*IN_WIDTH-1:0]  B_flat,
  output logic                         outReady,
  output logic                         frameErr,
  output logic [VCNT_W-1:0]            vecCount
);

  localparam int               IDX_W    = idx_width(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic [IDX_W-1:0]  w_lane;
  logic              w_accept;
  logic              w_copy;
  logic              w_restart;
  logic              r_out_ready;
  logic              r_frame_err;
  logic [VCNT_W-1:0] r_vec_count;

  // Element acceptance, lane select and next index. A start always lands in
  // lane 0; a start arriving mid-vector abandons the partial vector.
  always_comb begin
    w_accept   = enable & inValid;
    w_lane     = inStart ? '0 : r_idx;
    w_copy     = w_accept & ~inStart & (r_idx == LAST_IDX);
    w_restart  = w_accept & inStart & (r_idx != '0);
    w_idx_next = r_idx;
    if (w_accept) begin
      if (inStart) begin
        w_idx_next = IDX_W'(1);
      end else if (r_idx == LAST_IDX) begin
        w_idx_next = '0;
      end else begin
        w_idx_next = r_idx + IDX_W'(1);
      end
    end
  end

  // Index, strobe, sticky error and vector counter; everything holds while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_out_ready <= 1'b0;
      r_frame_err <= 1'b0;
      r_vec_count <= '0;
    end else if (enable) begin
      r_idx       <= w_idx_next;
      r_out_ready <= w_copy;
      if (w_restart) begin
        r_frame_err <= 1'b1;
      end
      if (w_copy) begin
        r_vec_count <= r_vec_count + VCNT_W'(1);
      end
    end
  end

  operand_lane_bank #(
    .IN_WIDTH (IN_WIDTH),
    .VEC_LEN  (VEC_LEN),
    .IDX_W    (IDX_W)
  ) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .i_wr_en (w_accept),
    .i_copy  (w_copy),
    .i_lane  (w_lane),
    .i_dat   (inA),
    .o_flat  (A_flat)
  );

  operand_lane_bank #(
    .IN_WIDTH (IN_WIDTH),
    .VEC_LEN  (VEC_LEN),
    .IDX_W    (IDX_W)
  ) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .i_wr_en (w_accept),
    .i_copy  (w_copy),
    .i_lane  (w_lane),
    .i_dat   (inB),
    .o_flat  (B_flat)
  );

  assign outReady = r_out_ready;
  assign frameErr = r_frame_err;
  assign vecCount = r_vec_count;

endmodule

// File: tb/tb_dot_product_operand_loader.sv
// Scoreboard bench for dot_product_operand_loader: directed vectors, decoupled monitor.
// Latency: expects each vector one cycle after its last element is accepted.
// Backpressure: exercises inValid gaps and enable stalls, including during outReady.
module tb_dot_product_operand_loader;

  localparam int W  = 10;
  localparam int N  = 16;
  localparam int FW = W * N;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                inValid;
  logic                inStart;
  logic signed [W-1:0] inA;
  logic signed [W-1:0] inB;
  logic [FW-1:0]       A_flat;
  logic [FW-1:0]       B_flat;
  logic                outReady;
  logic                frameErr;
  logic [15:0]         vecCount;

  dot_product_operand_loader #(.IN_WIDTH(W), .VEC_LEN(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .inValid  (inValid),
    .inStart  (inStart),
    .inA      (inA),
    .inB      (inB),
    .A_flat   (A_flat),
    .B_flat   (B_flat),
    .outReady (outReady),
    .frameErr (frameErr),
    .vecCount (vecCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic [15:0]   cnt;
  } exp_t;

  exp_t                sb[$];
  int                  n_vec = 0;
  int                  n_bad = 0;
  int                  cyc = 0;
  int                  prev_pulse = -1;
  int                  last_pulse = -1;
  logic [15:0]         exp_cnt = '0;
  logic signed [W-1:0] va[N];
  logic signed [W-1:0] vb[N];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one pop per enabled outReady cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (outReady === 1'b1 && enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_outReady", FW'(outReady), FW'(0));
      end else begin
        e = sb.pop_front();
        chk("A_flat", A_flat, e.a);
        chk("B_flat", B_flat, e.b);
        chk("vecCount", FW'(vecCount), FW'(e.cnt));
        prev_pulse = last_pulse;
        last_pulse = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    for (int k = 0; k < N; k++) begin
      e.a[k*W +: W] = va[k];
      e.b[k*W +: W] = vb[k];
    end
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    enable  = 1'b1;
    inValid = 1'b0;
    inStart = 1'b0;
    repeat (n) step();
  endtask

  // Sends the first n_elem elements of va/vb; a full vector queues its expectation.
  task automatic send_vec(input bit start0, input bit rnd, input bit stall_end, input int n_elem);
    for (int k = 0; k < n_elem; k++) begin
      if (rnd) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          inStart = 1'($urandom_range(0, 1));
          inA     = W'($urandom);
          inB     = W'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            enable  = 1'b0;
            inValid = 1'($urandom_range(0, 1));
          end else begin
            enable  = 1'b1;
            inValid = 1'b0;
          end
          step();
        end
      end
      enable  = 1'b1;
      inValid = 1'b1;
      inStart = (k == 0) && start0;
      inA     = va[k];
      inB     = vb[k];
      if (k == N - 1) push_expected();
      step();
    end
    inValid = 1'b0;
    inStart = 1'b0;
    if (stall_end) begin
      enable  = 1'b0;
      inValid = 1'b1;
      inA     = W'(77);
      inB     = W'(-3);
      repeat (3) step();
      chk("outReady_held_in_stall", FW'(outReady), FW'(1));
      enable  = 1'b1;
      inValid = 1'b0;
      step();
      chk("outReady_cleared_after_stall", FW'(outReady), FW'(0));
    end
  endtask

  initial begin
    int sum;
    logic signed [W-1:0] ta;
    logic signed [W-1:0] tb;
    reset   = 1'b1;
    enable  = 1'b0;
    inValid = 1'b0;
    inStart = 1'b0;
    inA     = '0;
    inB     = '0;
    repeat (3) step();
    chk("rst_A_flat", A_flat, FW'(0));
    chk("rst_B_flat", B_flat, FW'(0));
    chk("rst_outReady", FW'(outReady), FW'(0));
    chk("rst_frameErr", FW'(frameErr), FW'(0));
    chk("rst_vecCount", FW'(vecCount), FW'(0));
    reset = 1'b0;
    idle(2);

    // Basic vector A=k, B=-k.
    for (int k = 0; k < N; k++) begin va[k] = W'(k); vb[k] = W'(-k); end
    send_vec(1'b1, 1'b0, 1'b0, N);
    idle(3);
    chk("t1_vecCount", FW'(vecCount), FW'(1));
    chk("t1_frameErr", FW'(frameErr), FW'(0));

    // Back-to-back vectors; second has no start (follows a completed vector).
    for (int k = 0; k < N; k++) begin va[k] = W'(2*k + 1); vb[k] = W'(100 - 7*k); end
    send_vec(1'b1, 1'b0, 1'b0, N);
    for (int k = 0; k < N; k++) begin va[k] = W'(-30*k); vb[k] = W'(31*k); end
    send_vec(1'b0, 1'b0, 1'b0, N);
    idle(1);
    chk("t2_pulse_spacing", FW'(last_pulse - prev_pulse), FW'(16));
    chk("t2_vecCount", FW'(vecCount), FW'(3));

    // Restart at idx=7 discards the partial vector and latches frameErr.
    for (int k = 0; k < N; k++) begin va[k] = W'(k + 50); vb[k] = W'(k + 60); end
    send_vec(1'b1, 1'b0, 1'b0, 7);
    for (int k = 0; k < N; k++) begin va[k] = W'(200 - k); vb[k] = W'(-3*k - 1); end
    send_vec(1'b1, 1'b0, 1'b0, N);
    idle(2);
    chk("t3_frameErr_set", FW'(frameErr), FW'(1));
    chk("t3_vecCount", FW'(vecCount), FW'(4));

    // Gaps and enable stalls, then enable low while outReady is up.
    for (int k = 0; k < N; k++) begin va[k] = W'(k); vb[k] = W'(-k); end
    send_vec(1'b1, 1'b1, 1'b1, N);
    idle(2);

    // Extreme values in every lane, no start on element 0.
    for (int k = 0; k < N; k++) begin va[k] = W'(-512); vb[k] = W'(511); end
    send_vec(1'b0, 1'b0, 1'b0, N);
    idle(2);
    sum = 0;
    for (int k = 0; k < N; k++) begin
      ta  = A_flat[k*W +: W];
      tb  = B_flat[k*W +: W];
      sum = sum + int'(ta) * int'(tb);
    end
    chk("t5_dot_product", FW'(sum), FW'(-4186112));
    chk("t5_frameErr_sticky", FW'(frameErr), FW'(1));

    // Reset in the middle of a vector (idx=9).
    for (int k = 0; k < N; k++) begin va[k] = W'(k + 300); vb[k] = W'(-k - 300); end
    send_vec(1'b1, 1'b0, 1'b0, 9);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_A_flat", A_flat, FW'(0));
    chk("mid_rst_B_flat", B_flat, FW'(0));
    chk("mid_rst_outReady", FW'(outReady), FW'(0));
    chk("mid_rst_frameErr", FW'(frameErr), FW'(0));
    chk("mid_rst_vecCount", FW'(vecCount), FW'(0));
    exp_cnt = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin va[k] = W'(k*k - 100); vb[k] = W'(-20*k); end
    send_vec(1'b0, 1'b0, 1'b0, N);
    idle(2);
    chk("t6_vecCount", FW'(vecCount), FW'(1));
    chk("t6_frameErr", FW'(frameErr), FW'(0));

    for (int t = 0; t < 20 && sb.size() != 0; t++) step();
    chk("scoreboard_drained", FW'(sb.size()), FW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
